servo_scheduler: RTL and testbench
==================================

SERVO_SCHEDULER -- requirements
Module: servo_scheduler

Interface
REQ-001 SHALL provide parameter HOME, default 128: reset/home servo position.
REQ-002 SHALL provide parameter STEP, default 8: target change per manual step pulse.
REQ-003 SHALL provide parameter SLEW, default 2: max |q change| per frame pulse; legal 1..255.
REQ-004 SHALL provide parameter DWELL, default 25: frame pulses held at each sweep end; legal >=1.
REQ-005 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port cnt  in  1  one-cycle manual step pulse from the encoder decoder.
REQ-008 SHALL have port dir  in  1  step direction, sampled with cnt; 1 = increase, 0 = decrease.
REQ-009 SHALL have port mode  in  1  one-cycle pulse toggling manual/sweep.
REQ-010 SHALL have port frame  in  1  one-cycle pulse per PWM frame from the servo driver timebase.
REQ-011 SHALL have port q  out  8  registered position to servo driver.
REQ-012 SHALL have port level  out  8  thermometer of q: level[i] = (q[7:5] >= i).
REQ-013 SHALL have port m_set  out  1  high when state = MANUAL.
REQ-014 SHALL have port m_drv  out  1  high when q != target (servo moving).

Function
REQ-015 SHALL hold internal 8-bit target, saved, 1-bit sdir, dwell counter; states MANUAL, SWEEP, DWELL, RETURN.
REQ-016 SHALL change q only on frame: q<target -> min(q+SLEW,target); q>target -> max(q-SLEW,target); 9-bit math, no wrap.
REQ-017 SHALL, in MANUAL on cnt, set target = target+STEP (dir=1) or target-STEP (dir=0), saturated to 0..255.
REQ-018 SHALL, in MANUAL on mode, set saved=target, sdir=1, target=255, go SWEEP.
REQ-019 SHALL, in SWEEP on frame with q==target (pre-slew), go DWELL with dwell counter = 0.
REQ-020 SHALL, in DWELL, count frame pulses; on the DWELL-th, toggle sdir, target = sdir_new ? 255 : 0, go SWEEP.
REQ-021 SHALL, in SWEEP or DWELL on mode, set target=saved, go RETURN.
REQ-022 SHALL, in RETURN, go MANUAL when q==saved; mode ignored in RETURN.
REQ-023 SHALL, on cnt in SWEEP, DWELL or RETURN, preempt: target = sat(q +/- STEP) per dir, go MANUAL.
REQ-024 SHALL give cnt priority over mode in the same cycle; mode dropped.
REQ-025 SHALL, on cnt and frame in same cycle, slew q toward the old target; new target effective next frame.
REQ-026 SHALL ignore cnt/dir/mode/frame changes outside their pulse cycles; no internal edge detection.

Reset
REQ-027 SHALL, with rst_n low at a clk edge, set q=target=saved=HOME, state MANUAL, sdir=1, dwell=0, regardless of state or pending pulses.
REQ-028 SHALL, after reset, output level per q=HOME (0x1F for 128), m_set=1, m_drv=0; reset mid-sweep same.

Verification
REQ-029 Reset: rst_n low 2 cycles mid-sweep at q=200 -> q=128, level=0x1F, m_set=1, m_drv=0.
REQ-030 Manual: 3 cnt dir=1 -> target 152, m_drv=1; 12 frames -> q=152, m_drv=0.
REQ-031 Saturation: target 250, cnt dir=1 twice -> target 255; target 5, cnt dir=0 -> 0.
REQ-032 Sweep: mode at q=128 -> m_set=0; q=255 after 64 frames; q holds 25 frames; then decreases by 2 per frame.
REQ-033 Preempt: cnt dir=0 in SWEEP at q=200 -> MANUAL, target=192, m_set=1 next cycle; simultaneous mode ignored.
REQ-034 Return: mode during DWELL at q=255, saved=128 -> q reaches 128 after 64 frames, then MANUAL, m_set=1.

Source files
------------

// File: rtl/servo_scheduler.sv
// servo_scheduler: position scheduler for one hobby servo.
//   Manual mode: encoder step pulses nudge a target by STEP (saturating).
//   Sweep mode : target bounces between 0 and 255, holding DWELL frames at
//                each end; leaving sweep returns to the saved manual target.
//   q slews toward target by at most SLEW per PWM frame pulse.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   cnt, dir       one-cycle step pulse and its direction (1 = up)
//   mode           one-cycle pulse toggling manual/sweep
//   frame          one-cycle pulse per PWM frame
//   q              registered servo position
//   level          thermometer of q[7:5]
//   m_set          high in manual state
//   m_drv          high while q differs from target
module servo_scheduler #(
  parameter int HOME  = 128,
  parameter int STEP  = 8,
  parameter int SLEW  = 2,
  parameter int DWELL = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cnt,
  input  logic       dir,
  input  logic       mode,
  input  logic       frame,
  output logic [7:0] q,
  output logic [7:0] level,
  output logic       m_set,
  output logic       m_drv
);

  // Dwell counter runs 0..DWELL-1; the frame seen at DWELL-1 ends the hold.
  localparam int              DW      = (DWELL < 2) ? 1 : $clog2(DWELL);
  localparam logic [DW-1:0]   DW_LAST = DW'(DWELL - 1);

  typedef enum logic [1:0] {S_MANUAL, S_SWEEP, S_DWELL, S_RETURN} state_t;

  state_t        state, state_n;
  logic [7:0]    target, target_n, saved, saved_n, q_n;
  logic          sdir, sdir_n;
  logic [DW-1:0] dwell, dwell_n;

  // base +/- STEP clamped to 0..255; 10-bit math so the carry is visible.
  function automatic logic [7:0] step_sat(input logic [7:0] base, input logic up);
    logic [9:0] s;
    if (up) begin
      s = {2'b00, base} + 10'(STEP);
      return (s > 10'd255) ? 8'hFF : s[7:0];
    end
    if ({2'b00, base} < 10'(STEP)) return 8'h00;
    s = {2'b00, base} - 10'(STEP);
    return s[7:0];
  endfunction

  // One frame of slew toward tgt, never overshooting.
  function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] s;
    if (cur < tgt) begin
      s = {1'b0, cur} + 9'(SLEW);
      return (s >= {1'b0, tgt}) ? tgt : s[7:0];
    end
    if (cur > tgt) begin
      if ({1'b0, cur} <= ({1'b0, tgt} + 9'(SLEW))) return tgt;
      s = {1'b0, cur} - 9'(SLEW);
      return s[7:0];
    end
    return cur;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_MANUAL;
      q      <= 8'(HOME);
      target <= 8'(HOME);
      saved  <= 8'(HOME);
      sdir   <= 1'b1;
      dwell  <= '0;
    end else begin
      state  <= state_n;
      q      <= q_n;
      target <= target_n;
      saved  <= saved_n;
      sdir   <= sdir_n;
      dwell  <= dwell_n;
    end
  end

  // Next state. Slew always uses the current target, so a target changed in
  // the same cycle as a frame takes effect on the following frame.
  always_comb begin
    state_n  = state;
    target_n = target;
    saved_n  = saved;
    sdir_n   = sdir;
    dwell_n  = dwell;
    q_n      = frame ? slew(q, target) : q;

    case (state)
      S_MANUAL: begin
        if (cnt) begin
          target_n = step_sat(target, dir);
        end else if (mode) begin
          saved_n  = target;
          sdir_n   = 1'b1;
          target_n = 8'hFF;
          state_n  = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (cnt) begin
          target_n = step_sat(q, dir);
          state_n  = S_MANUAL;
        end else if (mode) begin
          target_n = saved;
          state_n  = S_RETURN;
        end else if (frame && (q == target)) begin
          dwell_n = '0;
          state_n = S_DWELL;
        end
      end
      S_DWELL: begin
        if (cnt) begin
          target_n = step_sat(q, dir);
          state_n  = S_MANUAL;
        end else if (mode) begin
          target_n = saved;
          state_n  = S_RETURN;
        end else if (frame) begin
          if (dwell == DW_LAST) begin
            sdir_n   = ~sdir;
            target_n = sdir ? 8'h00 : 8'hFF;  // sdir_new = ~sdir
            dwell_n  = '0;
            state_n  = S_SWEEP;
          end else begin
            dwell_n = dwell + 1'b1;
          end
        end
      end
      S_RETURN: begin
        // mode is deliberately ignored while returning
        if (cnt) begin
          target_n = step_sat(q, dir);
          state_n  = S_MANUAL;
        end else if (q == saved) begin
          state_n = S_MANUAL;
        end
      end
      default: state_n = S_MANUAL;
    endcase
  end

  // Outputs.
  always_comb begin
    m_set = (state == S_MANUAL);
    m_drv = (q != target);
    for (int i = 0; i < 8; i++) level[i] = (q[7:5] >= 3'(i));
  end

endmodule

// File: tb/tb_servo_scheduler.sv
module tb_servo_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cnt = 1'b0, dir = 1'b0, mode = 1'b0, frame = 1'b0;
  logic [7:0] q, level;
  logic       m_set, m_drv;
  int         n_tests = 0;
  int         n_fail  = 0;

  servo_scheduler dut (
    .clk(clk), .rst_n(rst_n), .cnt(cnt), .dir(dir), .mode(mode),
    .frame(frame), .q(q), .level(level), .m_set(m_set), .m_drv(m_drv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic c, input logic d, input logic m, input logic f);
    cnt = c; dir = d; mode = m; frame = f;
    tick();
    cnt = 1'b0; mode = 1'b0; frame = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) pulse(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

  initial begin
    // reset state
    do_reset();
    chk("rst_q", q, 128);
    chk("rst_level", level, 8'h1F);
    chk("rst_mset", m_set, 1);
    chk("rst_mdrv", m_drv, 0);

    // manual steps and slew
    repeat (3) pulse(1'b1, 1'b1, 1'b0, 1'b0);
    chk("man_target", dut.target, 152);
    chk("man_mdrv", m_drv, 1);
    frames(11);
    chk("man_q11", q, 150);
    frames(1);
    chk("man_q12", q, 152);
    chk("man_mdrv_done", m_drv, 0);
    chk("man_level", level, 8'h1F);
    chk("man_mset", m_set, 1);

    // cnt with frame: slew toward the old target
    pulse(1'b1, 1'b1, 1'b0, 1'b1);
    chk("cf_q", q, 152);
    chk("cf_target", dut.target, 160);
    frames(1);
    chk("cf_q_next", q, 154);

    // sweep up, dwell, then down
    do_reset();
    chk("rst2_q", q, 128);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sw_mset", m_set, 0);
    chk("sw_target", dut.target, 255);
    frames(63);
    chk("sw_q63", q, 254);
    frames(1);
    chk("sw_q64", q, 255);
    chk("sw_level", level, 8'hFF);
    frames(26);
    chk("sw_hold", q, 255);
    chk("sw_hold_mset", m_set, 0);
    frames(1);
    chk("sw_down", q, 253);
    chk("sw_down_mdrv", m_drv, 1);

    // reset mid-sweep at q=200
    do_reset();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    frames(36);
    chk("mid_q", q, 200);
    chk("mid_level", level, 8'h7F);
    do_reset();
    chk("mid_rst_q", q, 128);
    chk("mid_rst_level", level, 8'h1F);
    chk("mid_rst_mset", m_set, 1);
    chk("mid_rst_mdrv", m_drv, 0);

    // preempt with simultaneous mode
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    frames(36);
    chk("pre_q", q, 200);
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    chk("pre_mset", m_set, 1);
    chk("pre_target", dut.target, 192);
    tick();
    chk("pre_mset_hold", m_set, 1);
    chk("pre_target_hold", dut.target, 192);

    // return from dwell
    do_reset();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    frames(64);
    chk("ret_top", q, 255);
    frames(4);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ret_target", dut.target, 128);
    chk("ret_mset", m_set, 0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ret_mode_ign_t", dut.target, 128);
    chk("ret_mode_ign_m", m_set, 0);
    frames(63);
    chk("ret_q63", q, 129);
    frames(1);
    chk("ret_q64", q, 128);
    tick();
    chk("ret_manual", m_set, 1);

    // saturation
    do_reset();
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    frames(57);
    chk("sat_q242", q, 242);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat_t250", dut.target, 250);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat_t255", dut.target, 255);
    frames(7);
    chk("sat_q255", q, 255);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    frames(1);
    frames(24);
    chk("dw_24", dut.target, 255);
    frames(1);
    chk("dw_25", dut.target, 0);
    frames(121);
    chk("sat_q13", q, 13);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat_t5", dut.target, 5);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat_t0", dut.target, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
